wshb_arbiter: RTL and testbench

WSHB_ARBITER -- requirements
Module: wshb_arbiter

---
 rtl/wshb_arb_pkg.sv | 16 +
 rtl/wshb_if.sv | 27 ++
 rtl/wshb_arbiter.sv | 144 ++++++++++++++
 tb/tb_wshb_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wshb_arb_pkg.sv
// Shared types and defaults for the two-requester Wishbone arbiter.
package wshb_arb_pkg;

  localparam int MAX_XFER_DEFAULT = 64;
  localparam int ADR_W = 32;
  localparam int DAT_W = 32;
  localparam int SEL_W = DAT_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2,
    GAP  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/wshb_if.sv
// Classic Wishbone bus bundle; master drives the request, slave the response.
interface wshb_if;

  logic [wshb_arb_pkg::ADR_W-1:0] adr;
  logic [wshb_arb_pkg::DAT_W-1:0] dat_ms;
  logic [wshb_arb_pkg::DAT_W-1:0] dat_sm;
  logic                           we;
  logic [wshb_arb_pkg::SEL_W-1:0] sel;
  logic                           stb;
  logic                           cyc;
  logic [2:0]                     cti;
  logic [1:0]                     bte;
  logic                           ack;
  logic                           err;
  logic                           rty;

  modport master (
    output adr, dat_ms, we, sel, stb, cyc, cti, bte,
    input  dat_sm, ack, err, rty
  );

  modport slave (
    input  adr, dat_ms, we, sel, stb, cyc, cti, bte,
    output dat_sm, ack, err, rty
  );

endinterface

// File: rtl/wshb_arbiter.sv
// Two-requester Wishbone arbiter: fixed or round-robin pick from IDLE, bounded
// burst length while the other side waits, and a one-cycle bus-idle GAP between owners.
module wshb_arbiter
  import wshb_arb_pkg::*;
#(
  parameter int MAX_XFER = MAX_XFER_DEFAULT,
  parameter bit PRIO0    = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  wshb_if.slave      wshb_ifs0,
  wshb_if.slave      wshb_ifs1,
  wshb_if.master     wshb_ifm,
  output logic [1:0] grant
);

  localparam int               CNT_W    = $clog2(MAX_XFER + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_XFER);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_XFER - 1);

  arb_state_t       state, state_nxt;
  logic [CNT_W-1:0] xfer_cnt, xfer_cnt_nxt;
  logic             last_served, last_served_nxt;
  logic             req0, req1, term;
  logic             owner_req, other_req, owner_id;

  assign req0 = wshb_ifs0.cyc;
  assign req1 = wshb_ifs1.cyc;
  assign term = wshb_ifm.ack | wshb_ifm.err | wshb_ifm.rty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      xfer_cnt    <= '0;
      last_served <= 1'b1;
    end else begin
      state       <= state_nxt;
      xfer_cnt    <= xfer_cnt_nxt;
      last_served <= last_served_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    xfer_cnt_nxt    = xfer_cnt;
    last_served_nxt = last_served;
    owner_id        = (state == OWN1);
    owner_req       = owner_id ? req1 : req0;
    other_req       = owner_id ? req0 : req1;
    case (state)
      IDLE: begin
        xfer_cnt_nxt = '0;
        if (req0 && req1) begin
          state_nxt = (PRIO0 || last_served) ? OWN0 : OWN1;
        end else if (req0) begin
          state_nxt = OWN0;
        end else if (req1) begin
          state_nxt = OWN1;
        end
      end
      OWN0, OWN1: begin
        if (!owner_req) begin
          state_nxt       = GAP;
          last_served_nxt = owner_id;
        end else if (term) begin
          // Hand over only on a terminating ack, so no bus cycle is ever split.
          if (other_req && (xfer_cnt >= CNT_LAST)) begin
            state_nxt       = GAP;
            last_served_nxt = owner_id;
          end
          if (xfer_cnt != CNT_MAX) begin
            xfer_cnt_nxt = xfer_cnt + CNT_W'(1);
          end
        end
      end
      GAP: begin
        xfer_cnt_nxt = '0;
        if (last_served ? req0 : req1) begin
          state_nxt = last_served ? OWN0 : OWN1;
        end else if (last_served ? req1 : req0) begin
          state_nxt = last_served ? OWN1 : OWN0;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Only the current owner is connected; everything else is held at zero.
  always_comb begin
    grant            = 2'b00;
    wshb_ifm.adr     = '0;
    wshb_ifm.dat_ms  = '0;
    wshb_ifm.we      = 1'b0;
    wshb_ifm.sel     = '0;
    wshb_ifm.stb     = 1'b0;
    wshb_ifm.cyc     = 1'b0;
    wshb_ifm.cti     = '0;
    wshb_ifm.bte     = '0;
    wshb_ifs0.dat_sm = '0;
    wshb_ifs0.ack    = 1'b0;
    wshb_ifs0.err    = 1'b0;
    wshb_ifs0.rty    = 1'b0;
    wshb_ifs1.dat_sm = '0;
    wshb_ifs1.ack    = 1'b0;
    wshb_ifs1.err    = 1'b0;
    wshb_ifs1.rty    = 1'b0;
    case (state)
      OWN0: begin
        grant            = 2'b01;
        wshb_ifm.adr     = wshb_ifs0.adr;
        wshb_ifm.dat_ms  = wshb_ifs0.dat_ms;
        wshb_ifm.we      = wshb_ifs0.we;
        wshb_ifm.sel     = wshb_ifs0.sel;
        wshb_ifm.stb     = wshb_ifs0.stb;
        wshb_ifm.cyc     = wshb_ifs0.cyc;
        wshb_ifm.cti     = wshb_ifs0.cti;
        wshb_ifm.bte     = wshb_ifs0.bte;
        wshb_ifs0.dat_sm = wshb_ifm.dat_sm;
        wshb_ifs0.ack    = wshb_ifm.ack;
        wshb_ifs0.err    = wshb_ifm.err;
        wshb_ifs0.rty    = wshb_ifm.rty;
      end
      OWN1: begin
        grant            = 2'b10;
        wshb_ifm.adr     = wshb_ifs1.adr;
        wshb_ifm.dat_ms  = wshb_ifs1.dat_ms;
        wshb_ifm.we      = wshb_ifs1.we;
        wshb_ifm.sel     = wshb_ifs1.sel;
        wshb_ifm.stb     = wshb_ifs1.stb;
        wshb_ifm.cyc     = wshb_ifs1.cyc;
        wshb_ifm.cti     = wshb_ifs1.cti;
        wshb_ifm.bte     = wshb_ifs1.bte;
        wshb_ifs1.dat_sm = wshb_ifm.dat_sm;
        wshb_ifs1.ack    = wshb_ifm.ack;
        wshb_ifs1.err    = wshb_ifm.err;
        wshb_ifs1.rty    = wshb_ifm.rty;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wshb_arbiter.sv
// Bench for wshb_arbiter: vector table, directed corner sequences and a
// randomized run against a rule-level ownership model, on two parameterizations.
module tb_wshb_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] grant_a, grant_b;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  wshb_if a_s0 ();
  wshb_if a_s1 ();
  wshb_if a_m ();
  wshb_if b_s0 ();
  wshb_if b_s1 ();
  wshb_if b_m ();

  wshb_arbiter #(.MAX_XFER(4), .PRIO0(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .wshb_ifs0(a_s0), .wshb_ifs1(a_s1),
    .wshb_ifm(a_m), .grant(grant_a)
  );

  wshb_arbiter #(.MAX_XFER(3), .PRIO0(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .wshb_ifs0(b_s0), .wshb_ifs1(b_s1),
    .wshb_ifm(b_m), .grant(grant_b)
  );

  typedef struct {
    logic       c0;
    logic       c1;
    logic       ack;
    logic [1:0] grant;
    logic       mcyc;
    logic       ack0;
    logic       ack1;
  } vec_t;

  vec_t vecs[12];

  // Ownership model: mode 0 = idle, 1 = owned, 2 = gap.
  int       m_mode[2];
  int       m_owner[2];
  int       m_cnt[2];
  int       m_last[2];
  const int p_max[2]  = '{4, 3};
  const int p_prio[2] = '{1, 0};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clearInputs();
    a_s0.cyc = 0; a_s0.stb = 0; a_s0.adr = '0; a_s0.dat_ms = '0; a_s0.we = 0; a_s0.sel = '0; a_s0.cti = '0; a_s0.bte = '0;
    a_s1.cyc = 0; a_s1.stb = 0; a_s1.adr = '0; a_s1.dat_ms = '0; a_s1.we = 0; a_s1.sel = '0; a_s1.cti = '0; a_s1.bte = '0;
    b_s0.cyc = 0; b_s0.stb = 0; b_s0.adr = '0; b_s0.dat_ms = '0; b_s0.we = 0; b_s0.sel = '0; b_s0.cti = '0; b_s0.bte = '0;
    b_s1.cyc = 0; b_s1.stb = 0; b_s1.adr = '0; b_s1.dat_ms = '0; b_s1.we = 0; b_s1.sel = '0; b_s1.cti = '0; b_s1.bte = '0;
    a_m.dat_sm = '0; a_m.ack = 0; a_m.err = 0; a_m.rty = 0;
    b_m.dat_sm = '0; b_m.ack = 0; b_m.err = 0; b_m.rty = 0;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    clearInputs();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_owner[k] = 0; m_cnt[k] = 0; m_last[k] = 1;
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    a_s0.cyc = v.c0; a_s0.stb = v.c0;
    a_s1.cyc = v.c1; a_s1.stb = v.c1;
    a_m.ack  = v.ack;
  endtask

  task automatic modelExpect(input int k, input bit c0, input bit c1, input bit ack,
                             input logic [31:0] adr0, input logic [31:0] adr1, input logic [31:0] dat,
                             output logic [1:0] eg, output bit emc, output bit ea0, output bit ea1,
                             output logic [31:0] eadr, output logic [31:0] ed0, output logic [31:0] ed1);
    bit own;
    own  = (m_mode[k] == 1);
    eg   = !own ? 2'b00 : (m_owner[k] == 0 ? 2'b01 : 2'b10);
    emc  = own && (m_owner[k] == 0 ? c0 : c1);
    ea0  = own && m_owner[k] == 0 && ack;
    ea1  = own && m_owner[k] == 1 && ack;
    eadr = !own ? 32'h0 : (m_owner[k] == 0 ? adr0 : adr1);
    ed0  = (own && m_owner[k] == 0) ? dat : 32'h0;
    ed1  = (own && m_owner[k] == 1) ? dat : 32'h0;
  endtask

  task automatic modelUpdate(input int k, input bit c0, input bit c1, input bit ack);
    bit c[2];
    int o;
    c[0] = c0; c[1] = c1;
    if (m_mode[k] == 0) begin
      if (c0 && c1) begin
        m_mode[k] = 1; m_cnt[k] = 0;
        m_owner[k] = (p_prio[k] != 0) ? 0 : 1 - m_last[k];
      end else if (c0 || c1) begin
        m_mode[k] = 1; m_cnt[k] = 0; m_owner[k] = c0 ? 0 : 1;
      end
    end else if (m_mode[k] == 1) begin
      o = m_owner[k];
      if (!c[o]) begin
        m_mode[k] = 2; m_last[k] = o;
      end else if (ack) begin
        if (c[1-o] && m_cnt[k] + 1 >= p_max[k]) begin
          m_mode[k] = 2; m_last[k] = o;
        end
        if (m_cnt[k] < p_max[k]) m_cnt[k]++;
      end
    end else begin
      m_cnt[k] = 0;
      o = 1 - m_last[k];
      if (c[o]) begin
        m_mode[k] = 1; m_owner[k] = o;
      end else if (c[m_last[k]]) begin
        m_mode[k] = 1; m_owner[k] = m_last[k];
      end else begin
        m_mode[k] = 0;
      end
    end
  endtask

  initial begin
    int               acks1;
    bit               rc[2][2];
    logic [31:0]      ra[2][2];
    bit               rk[2];
    logic [31:0]      rd[2];
    logic [1:0]       eg;
    bit               emc, ea0, ea1;
    logic [31:0]      eadr, ed0, ed1;

    // Both streaming with MAX_XFER = 4: 01 x4, gap, 10 x4, gap, 01.
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0};

    // Reset held with both requesting, then release.
    clearInputs();
    rst_n = 1'b0;
    a_s0.cyc = 1; a_s0.stb = 1; a_s1.cyc = 1; a_s1.stb = 1; a_m.ack = 1;
    repeat (2) tick();
    checkOutput("rst grant", grant_a, 2'b00);
    checkOutput("rst mcyc", a_m.cyc, 1'b0);
    checkOutput("rst ack0", a_s0.ack, 1'b0);
    checkOutput("rst ack1", a_s1.ack, 1'b0);
    a_m.ack = 0;
    rst_n = 1'b1;
    #1;
    checkOutput("rel grant same cycle", grant_a, 2'b00);
    tick();
    checkOutput("rel grant next", grant_a, 2'b01);

    // Vector table.
    doReset();
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("vec%0d grant", i), grant_a, vecs[i].grant);
      checkOutput($sformatf("vec%0d mcyc", i), a_m.cyc, vecs[i].mcyc);
      checkOutput($sformatf("vec%0d ack0", i), a_s0.ack, vecs[i].ack0);
      checkOutput($sformatf("vec%0d ack1", i), a_s1.ack, vecs[i].ack1);
      tick();
    end

    // Requester 1 alone: 10 single reads, slave acks two cycles after stb.
    doReset();
    acks1 = 0;
    a_s1.cyc = 1;
    tick();
    checkOutput("solo grant", grant_a, 2'b10);
    for (int i = 0; i < 10; i++) begin
      a_s1.stb = 1; a_s1.adr = 32'(i);
      #1;
      checkOutput("solo mstb", a_m.stb, 1'b1);
      checkOutput("solo madr", a_m.adr, 32'(i));
      tick();
      tick();
      a_m.ack = 1; a_m.dat_sm = 32'(i + 100);
      #1;
      if (a_s1.ack === 1'b1) acks1++;
      checkOutput("solo ack0", a_s0.ack, 1'b0);
      checkOutput("solo dat1", a_s1.dat_sm, 32'(i + 100));
      checkOutput("solo dat0", a_s0.dat_sm, 32'h0);
      tick();
      a_m.ack = 0; a_s1.stb = 0;
      #1;
      checkOutput("solo no gap", grant_a, 2'b10);
    end
    checkOutput("solo ack count", 32'(acks1), 32'd10);

    // Requester 0 leaves after two acks with requester 1 idle.
    doReset();
    a_s0.cyc = 1; a_s0.stb = 1;
    tick();
    a_m.ack = 1;
    #1;
    checkOutput("drop ack0", a_s0.ack, 1'b1);
    tick();
    tick();
    a_m.ack = 0; a_s0.cyc = 0; a_s0.stb = 0;
    tick();
    checkOutput("drop gap grant", grant_a, 2'b00);
    checkOutput("drop gap mcyc", a_m.cyc, 1'b0);
    tick();
    tick();
    checkOutput("drop idle grant", grant_a, 2'b00);
    a_s1.cyc = 1; a_s1.stb = 1;
    #1;
    checkOutput("late req pending", grant_a, 2'b00);
    tick();
    checkOutput("late req grant", grant_a, 2'b10);

    // Reset during an OWN1 read, before the slave acks.
    doReset();
    a_s1.cyc = 1; a_s1.stb = 1; a_s1.adr = 32'hCAFE_0000;
    tick();
    checkOutput("abort mcyc before", a_m.cyc, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort mcyc", a_m.cyc, 1'b0);
    checkOutput("abort mstb", a_m.stb, 1'b0);
    checkOutput("abort madr", a_m.adr, 32'h0);
    checkOutput("abort grant", grant_a, 2'b00);
    a_m.ack = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("abort ack1", a_s1.ack, 1'b0);
      tick();
    end
    a_m.ack = 0; a_s1.cyc = 0; a_s1.stb = 0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("abort ack1 after", a_s1.ack, 1'b0);
    end

    // Round-robin instance: two simultaneous requests from IDLE.
    doReset();
    b_s0.cyc = 1; b_s0.stb = 1; b_s1.cyc = 1; b_s1.stb = 1;
    #1;
    checkOutput("rr idle", grant_b, 2'b00);
    tick();
    checkOutput("rr first", grant_b, 2'b01);
    b_s0.cyc = 0; b_s0.stb = 0; b_s1.cyc = 0; b_s1.stb = 0;
    tick();
    tick();
    checkOutput("rr back idle", grant_b, 2'b00);
    b_s0.cyc = 1; b_s0.stb = 1; b_s1.cyc = 1; b_s1.stb = 1;
    tick();
    checkOutput("rr second", grant_b, 2'b10);

    // Randomized run on both instances against the ownership model.
    doReset();
    for (int k = 0; k < 2; k++) begin
      rc[k][0] = 0; rc[k][1] = 0;
    end
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 2; k++) begin
        for (int r = 0; r < 2; r++) begin
          if ($urandom_range(0, 5) == 0) rc[k][r] = ~rc[k][r];
          ra[k][r] = $urandom;
        end
        rk[k] = 1'($urandom_range(0, 1));
        rd[k] = $urandom;
      end
      a_s0.cyc = rc[0][0]; a_s0.stb = rc[0][0]; a_s0.adr = ra[0][0];
      a_s1.cyc = rc[0][1]; a_s1.stb = rc[0][1]; a_s1.adr = ra[0][1];
      a_m.ack = rk[0]; a_m.dat_sm = rd[0];
      b_s0.cyc = rc[1][0]; b_s0.stb = rc[1][0]; b_s0.adr = ra[1][0];
      b_s1.cyc = rc[1][1]; b_s1.stb = rc[1][1]; b_s1.adr = ra[1][1];
      b_m.ack = rk[1]; b_m.dat_sm = rd[1];
      #1;
      modelExpect(0, rc[0][0], rc[0][1], rk[0], ra[0][0], ra[0][1], rd[0], eg, emc, ea0, ea1, eadr, ed0, ed1);
      checkOutput("rnd a grant", grant_a, eg);
      checkOutput("rnd a mcyc", a_m.cyc, emc);
      checkOutput("rnd a ack0", a_s0.ack, ea0);
      checkOutput("rnd a ack1", a_s1.ack, ea1);
      checkOutput("rnd a madr", a_m.adr, eadr);
      checkOutput("rnd a dat0", a_s0.dat_sm, ed0);
      checkOutput("rnd a dat1", a_s1.dat_sm, ed1);
      modelExpect(1, rc[1][0], rc[1][1], rk[1], ra[1][0], ra[1][1], rd[1], eg, emc, ea0, ea1, eadr, ed0, ed1);
      checkOutput("rnd b grant", grant_b, eg);
      checkOutput("rnd b mcyc", b_m.cyc, emc);
      checkOutput("rnd b ack0", b_s0.ack, ea0);
      checkOutput("rnd b ack1", b_s1.ack, ea1);
      checkOutput("rnd b madr", b_m.adr, eadr);
      checkOutput("rnd b dat0", b_s0.dat_sm, ed0);
      checkOutput("rnd b dat1", b_s1.dat_sm, ed1);
      modelUpdate(0, rc[0][0], rc[0][1], rk[0]);
      modelUpdate(1, rc[1][0], rc[1][1], rk[1]);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
